// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: round-robin grant with hold and hold limit (in clk rst req done; out gnt gnt_idx busy timeout)
module rr_grant_ctrl #(
  parameter int n = 8,
  parameter int m = 3,
  parameter int lim = 16,
  parameter int w = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] req,
  input  logic         done,
  output logic [n-1:0] gnt,
  output logic [m-1:0] gnt_idx,
  output logic         busy,
  output logic         timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [w-1:0] lim_m1 = w'(lim == 0 ? 0 : lim - 1);
  state_t st_q;
  logic [m-1:0] p_q, idx_q, pick, ix;
  logic [m:0] s;
  logic [w-1:0] cnt_q;
  logic [n-1:0] gnt_q;
  logic tmo_q, lim_hit, rel;
  always_comb begin
    pick = '0;
    s = '0;
    ix = '0;
    for (int k = n - 1; k >= 0; k--) begin
      s = {1'b0, p_q} + (m+1)'(k);
      ix = m'(s >= (m+1)'(n) ? s - (m+1)'(n) : s);
      pick = req[ix] ? ix : pick;
    end
  end
  assign lim_hit = (lim != 0) && (cnt_q == lim_m1);
  assign rel = done || !req[idx_q] || lim_hit;
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      p_q <= '0;
      cnt_q <= '0;
      gnt_q <= '0;
      idx_q <= '0;
      tmo_q <= 1'b0;
    end else if (st_q == IDLE) begin
      tmo_q <= 1'b0;
      if (|req) begin
        st_q <= GRANT;
        gnt_q <= {{(n-1){1'b0}}, 1'b1} << pick;
        idx_q <= pick;
        cnt_q <= '0;
      end
    end else if (rel) begin
      st_q <= IDLE;
      gnt_q <= '0;
      idx_q <= '0;
      p_q <= idx_q == m'(n - 1) ? '0 : idx_q + 1'b1;
      tmo_q <= !done && req[idx_q];
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
  assign gnt = gnt_q;
  assign gnt_idx = idx_q;
  assign busy = st_q == GRANT;
  assign timeout = tmo_q;
endmodule
